// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronised/filtered pad sampling, 11-bit frame capture, 3-byte packet decode.
// Optional PS2_MOUSE_INIT_EN adds the host-side 0xF4 (enable reporting) handshake after reset.
module ps2_mouse_rx #(
    parameter int unsigned CLK_FREQ_HZ      = 36_000_000,
    parameter int unsigned FRAME_TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic       is_mouse_x_neg,
    output logic       is_mouse_y_neg,
    output logic [2:0] mouse_btn,
    output logic       mouse_valid,
    output logic       frame_err
);

    localparam int unsigned CYC_PER_MS   = CLK_FREQ_HZ / 1000;
    localparam int unsigned FRAME_TO_CYC = CYC_PER_MS * FRAME_TIMEOUT_US / 1000;

    logic rx_en;
    logic in_stream;

    // Hysteresis vote: 3+ ones -> 1, 1- ones -> 0, a 2/2 split keeps the current value.
    function automatic logic vote(input logic [3:0] h, input logic cur);
        logic [2:0] ones;
        logic       res;
        ones = {2'b00, h[0]} + {2'b00, h[1]} + {2'b00, h[2]} + {2'b00, h[3]};
        if (ones >= 3'd3) begin
            res = 1'b1;
        end else if (ones <= 3'd1) begin
            res = 1'b0;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // |{sign, v}| saturated to 255; an overflow flag forces full scale.
    function automatic logic [7:0] delta_mag(input logic sign, input logic ovf,
                                             input logic [7:0] v);
        logic [8:0] neg;
        logic [7:0] res;
        neg = 9'h100 - {1'b0, v};
        if (ovf) begin
            res = 8'hFF;
        end else if (!sign) begin
            res = v;
        end else if (neg[8]) begin
            res = 8'hFF;
        end else begin
            res = neg[7:0];
        end
        return res;
    endfunction

    logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [3:0] clk_hist_q, dat_hist_q;
    logic       clk_filt_q, dat_filt_q, clk_prev_q;
    logic       fall;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_hist_q <= 4'hF;
            dat_hist_q <= 4'hF;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data_i;
            dat_s2_q   <= dat_s1_q;
            clk_hist_q <= {clk_hist_q[2:0], clk_s2_q};
            dat_hist_q <= {dat_hist_q[2:0], dat_s2_q};
            clk_filt_q <= vote(clk_hist_q, clk_filt_q);
            dat_filt_q <= vote(dat_hist_q, dat_filt_q);
            clk_prev_q <= clk_filt_q;
        end
    end

    assign fall = clk_prev_q & ~clk_filt_q;

    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [31:0] gap_q;
    logic        byte_done_q, byte_ok_q;
    logic        frame_timeout;

    assign frame_timeout = rx_en & ~fall & (bit_cnt_q != 4'd0) & (gap_q >= FRAME_TO_CYC);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            gap_q       <= 32'd0;
            byte_done_q <= 1'b0;
            byte_ok_q   <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (!rx_en) begin
                bit_cnt_q <= 4'd0;
                gap_q     <= 32'd0;
            end else if (fall) begin
                gap_q <= 32'd0;
                if (bit_cnt_q == 4'd0) begin
                    // A high start bit is noise; stay idle.
                    if (!dat_filt_q) bit_cnt_q <= 4'd1;
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q   <= {dat_filt_q, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else if (bit_cnt_q == 4'd9) begin
                    par_q     <= dat_filt_q;
                    bit_cnt_q <= 4'd10;
                end else begin
                    byte_done_q <= 1'b1;
                    byte_ok_q   <= (^{shift_q, par_q}) & dat_filt_q;
                    bit_cnt_q   <= 4'd0;
                end
            end else if (frame_timeout) begin
                bit_cnt_q <= 4'd0;
                gap_q     <= 32'd0;
            end else if (bit_cnt_q != 4'd0) begin
                gap_q <= gap_q + 32'd1;
            end
        end
    end

    logic [1:0] pkt_idx_q;
    logic [7:0] hdr_q, x_byte_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pkt_idx_q      <= 2'd0;
            hdr_q          <= 8'h00;
            x_byte_q       <= 8'h00;
            mouse_x        <= 8'h00;
            mouse_y        <= 8'h00;
            is_mouse_x_neg <= 1'b0;
            is_mouse_y_neg <= 1'b0;
            mouse_btn      <= 3'b000;
            mouse_valid    <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            mouse_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (frame_timeout) begin
                frame_err <= 1'b1;
                pkt_idx_q <= 2'd0;
            end else if (byte_done_q) begin
                if (!byte_ok_q) begin
                    frame_err <= 1'b1;
                    pkt_idx_q <= 2'd0;
                end else if (in_stream) begin
                    unique case (pkt_idx_q)
                        2'd0: begin
                            // Bit 3 is always set in a header; anything else is resync noise.
                            if (shift_q[3]) begin
                                hdr_q     <= shift_q;
                                pkt_idx_q <= 2'd1;
                            end
                        end
                        2'd1: begin
                            x_byte_q  <= shift_q;
                            pkt_idx_q <= 2'd2;
                        end
                        2'd2: begin
                            mouse_x        <= delta_mag(hdr_q[4], hdr_q[6], x_byte_q);
                            mouse_y        <= delta_mag(hdr_q[5], hdr_q[7], shift_q);
                            is_mouse_x_neg <= hdr_q[4];
                            is_mouse_y_neg <= hdr_q[5];
                            mouse_btn      <= hdr_q[2:0];
                            mouse_valid    <= 1'b1;
                            pkt_idx_q      <= 2'd0;
                        end
                        default: pkt_idx_q <= 2'd0;
                    endcase
                end
            end
        end
    end

`ifdef PS2_MOUSE_INIT_EN
    localparam int unsigned WAIT_CYC   = CYC_PER_MS * 500;
    localparam int unsigned INH_CYC    = CYC_PER_MS * 120 / 1000;
    localparam int unsigned DEV_TO_CYC = CYC_PER_MS * 20;
    localparam logic [8:0]  TX_FRAME   = {~^8'hF4, 8'hF4};

    typedef enum logic [2:0] {
        StInitWait, StInhibit, StReq, StTx, StAck, StResp, StStream
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  tx_idx_q, tx_idx_d;
    logic        clk_oe_q, data_oe_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StInitWait;
            timer_q   <= 32'd0;
            tx_idx_q  <= 4'd0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_idx_q  <= tx_idx_d;
            // Registered so the pads never see decode glitches.
            clk_oe_q  <= (state_q == StInhibit);
            data_oe_q <= (state_q == StReq) | ((state_q == StTx) & ~TX_FRAME[tx_idx_q]);
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 32'd1;
        tx_idx_d = tx_idx_q;
        unique case (state_q)
            StInitWait: if (timer_q >= WAIT_CYC - 1) state_d = StInhibit;
            StInhibit:  if (timer_q >= INH_CYC - 1) state_d = StReq;
            StReq: begin
                if (fall) begin
                    state_d  = StTx;
                    tx_idx_d = 4'd0;
                end
            end
            StTx: begin
                if (fall) begin
                    timer_d = 32'd0;
                    if (tx_idx_q == 4'd8) state_d = StAck;
                    else tx_idx_d = tx_idx_q + 4'd1;
                end
            end
            StAck: if (fall) state_d = dat_filt_q ? StInhibit : StResp;
            StResp: begin
                if (fall) timer_d = 32'd0;
                if (byte_done_q) begin
                    state_d = (byte_ok_q && shift_q == 8'hFA) ? StStream : StInhibit;
                end
            end
            StStream: timer_d = 32'd0;
            default:  state_d = StInitWait;
        endcase
        // A silent device during the handshake restarts it from the inhibit pulse.
        if ((state_q inside {StReq, StTx, StAck, StResp}) && timer_q >= DEV_TO_CYC) begin
            state_d = StInhibit;
        end
        if (state_d != state_q) timer_d = 32'd0;
    end

    assign rx_en       = (state_q == StResp) || (state_q == StStream);
    assign in_stream   = (state_q == StStream);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
`else
    assign rx_en       = 1'b1;
    assign in_stream   = 1'b1;
    assign ps2_clk_oe  = 1'b0;
    assign ps2_data_oe = 1'b0;
`endif

endmodule
